hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Generates the hold/flush controls the IF/ID buffer and PC register consume: IFIDWrite, PCWrite,
//  ID/EX bubble select and IF/ID flush. Detects load-use hazards, freezes the pipe on a
//  multi-cycle data-memory wait, and defers taken-branch flushes that arrive during a freeze.
//  It sits beside the ID stage and drives the write-enable inputs of the IF/ID and PC registers.
// PARAMETERS
//  REG_AW       5    register-specifier width
//  MEM_TIMEOUT  64   max wait cycles on dmem_ready before abort (>=2)
//  CNT_W        16   width of the stall statistics counter
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  idex_memread  in   1       instruction in EX is a load
//  idex_rt       in   REG_AW  load destination register in EX
//  ifid_rs       in   REG_AW  source reg 1 of instruction in ID
//  ifid_rt       in   REG_AW  source reg 2 of instruction in ID
//  branch_taken  in   1       ID resolved a taken branch/jump this cycle
//  dmem_req      in   1       MEM stage issues a data-memory access this cycle
//  dmem_ready    in   1       data memory completes the access this cycle
//  IFIDWrite     out  1       1 = IF/ID buffer loads; 0 = holds
//  PCWrite       out  1       1 = PC updates; 0 = holds
//  ctrl_bubble   out  1       1 = zero ID/EX control (insert NOP)
//  ifid_flush    out  1       1 = IF/ID buffer loads a NOP
//  pipe_freeze   out  1       1 = EX/MEM and MEM/WB must hold
//  mem_err       out  1       sticky: a memory wait hit MEM_TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, wait_cnt=0, flush_pend=0, mem_err=0; outputs IFIDWrite=1,
//   PCWrite=1, ctrl_bubble=0, ifid_flush=0, pipe_freeze=0. Reset mid-wait aborts the wait silently.
//  Outputs are combinational from state, registers and inputs (zero-cycle latency).
//  load_use = idex_memread & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
//  FSM states RUN, MEM_WAIT:
//   RUN: if dmem_req & !dmem_ready -> freeze now (IFIDWrite=0,PCWrite=0,pipe_freeze=1), next MEM_WAIT,
//        wait_cnt<=1. Else if load_use -> IFIDWrite=0, PCWrite=0, ctrl_bubble=1 for this cycle only.
//        Else if branch_taken | flush_pend -> ifid_flush=1, flush_pend<=0. Else all pass (1,1,0,0).
//   MEM_WAIT: IFIDWrite=0, PCWrite=0, pipe_freeze=1, ctrl_bubble=0, ifid_flush=0.
//        dmem_ready -> RUN, wait_cnt<=0 (release visible next cycle).
//        else wait_cnt==MEM_TIMEOUT-1 -> mem_err<=1, RUN, wait_cnt<=0; else wait_cnt++.
//  Priority in a cycle: memory freeze > load-use > branch flush.
//  branch_taken while frozen or load-use stalled: flush_pend<=1; flush issues on first free RUN cycle.
//  Load-use and branch_taken in same cycle: stall wins, flush deferred via flush_pend.
//  mem_err stays 1 until reset; it does not block further operation.
//  wait_cnt width = $clog2(MEM_TIMEOUT+1); never wraps (bounded by timeout).
// CONFIGURATION
//  HAZ_STATS_EN defined: adds outputs stall_cnt [CNT_W-1:0] (+1 every cycle IFIDWrite==0)
//   and flush_cnt [CNT_W-1:0] (+1 each ifid_flush); both saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package pipe_pkg: state enum (RUN, MEM_WAIT), REG_AW, zero-register constant.
//  One sub-module: hazard_detect (pure combinational load_use compare), reused by forwarding logic.
//  FSM, wait counter, flush_pend and optional stats stay in this module.
// TESTING
//  1 Reset: rst_n=0 mid-MEM_WAIT -> outputs return to (1,1,0,0,0), mem_err=0 immediately.
//  2 Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> IFIDWrite=0, PCWrite=0, ctrl_bubble=1 one cycle;
//    same with idex_rt=0 -> no stall.
//  3 Mem wait: dmem_req=1, dmem_ready low 3 cycles -> freeze 4 cycles total incl. ready cycle; pass after.
//  4 Timeout: MEM_TIMEOUT=8, dmem_ready never -> mem_err=1 after 8 frozen cycles, back to RUN.
//  5 Deferred flush: branch_taken during load-use stall -> ifid_flush=1 exactly on next cycle, once.
//  6 HAZ_STATS_EN: 3 stall cycles + 1 flush -> stall_cnt=3, flush_cnt=1; force to max -> holds all-ones.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, register-specifier
// width and the hard-wired zero register number.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;

    // Register 0 is hard-wired to zero, so writes to it never create a hazard.
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard compare: flags an instruction in ID that reads the
// destination of a load currently in EX. Pure combinational so the same
// compare can be reused by the forwarding logic.
//
// Ports:
//   idex_memread  in   instruction in EX is a load
//   idex_rt       in   load destination register in EX
//   ifid_rs       in   source register 1 of the instruction in ID
//   ifid_rt       in   source register 2 of the instruction in ID
//   load_use      out  ID consumes the EX load result (stall required)
module hazard_detect #(
    parameter int unsigned AW = pipe_pkg::REG_AW
) (
    input  logic          idex_memread,
    input  logic [AW-1:0] idex_rt,
    input  logic [AW-1:0] ifid_rs,
    input  logic [AW-1:0] ifid_rt,
    output logic          load_use
);
    import pipe_pkg::*;

    // A load targeting the zero register produces nothing to wait for.
    always_comb begin
        load_use = idex_memread
                 && (idex_rt != AW'(ZERO_REG))
                 && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

endmodule : hazard_detect

// File: rtl/hazard_stall_ctrl.sv
// Hold/flush control for the IF/ID buffer and PC register. Stalls one cycle
// on a load-use hazard, freezes the whole pipe while data memory is busy
// (with a timeout that sets a sticky error), and defers taken-branch flushes
// that arrive while the front end is held.
//
// Optional feature macro: HAZ_STATS_EN adds saturating stall/flush counters.
//
// Ports:
//   clk, rst_n     in   clock, asynchronous active-low reset
//   idex_memread   in   instruction in EX is a load
//   idex_rt        in   load destination register in EX
//   ifid_rs        in   source register 1 of instruction in ID
//   ifid_rt        in   source register 2 of instruction in ID
//   branch_taken   in   ID resolved a taken branch/jump this cycle
//   dmem_req       in   MEM stage issues a data-memory access this cycle
//   dmem_ready     in   data memory completes the access this cycle
//   IFIDWrite      out  1 = IF/ID buffer loads, 0 = holds (combinational)
//   PCWrite        out  1 = PC updates, 0 = holds (combinational)
//   ctrl_bubble    out  1 = zero ID/EX control (combinational)
//   ifid_flush     out  1 = IF/ID buffer loads a NOP (combinational)
//   pipe_freeze    out  1 = EX/MEM and MEM/WB hold (combinational)
//   mem_err        out  sticky memory-wait timeout flag (registered)
//   stall_cnt      out  [HAZ_STATS_EN] cycles with IFIDWrite==0, saturating
//   flush_cnt      out  [HAZ_STATS_EN] ifid_flush pulses, saturating
module hazard_stall_ctrl #(
    parameter int unsigned REG_AW      = pipe_pkg::REG_AW,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              IFIDWrite,
    output logic              PCWrite,
    output logic              ctrl_bubble,
    output logic              ifid_flush,
    output logic              pipe_freeze,
    output logic              mem_err
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    import pipe_pkg::*;

    localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    pipe_state_e    state_q, state_nxt;
    logic [WCW-1:0] wait_q, wait_nxt;
    logic           flush_pend_q, flush_pend_nxt;
    logic           mem_err_q, mem_err_nxt;
    logic           load_use;

    // Load-use compare against the instruction sitting in ID.
    hazard_detect #(
        .AW (REG_AW)
    ) u_hazard_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .load_use     (load_use)
    );

    // State, wait counter, pending flush and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wait_q       <= '0;
            flush_pend_q <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            wait_q       <= wait_nxt;
            flush_pend_q <= flush_pend_nxt;
            mem_err_q    <= mem_err_nxt;
        end
    end

    // Next state and zero-latency control outputs.
    // Priority: memory freeze > load-use stall > branch flush.
    always_comb begin
        state_nxt      = state_q;
        wait_nxt       = wait_q;
        flush_pend_nxt = flush_pend_q;
        mem_err_nxt    = mem_err_q;
        IFIDWrite      = 1'b1;
        PCWrite        = 1'b1;
        ctrl_bubble    = 1'b0;
        ifid_flush     = 1'b0;
        pipe_freeze    = 1'b0;

        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    IFIDWrite   = 1'b0;
                    PCWrite     = 1'b0;
                    pipe_freeze = 1'b1;
                    state_nxt   = MEM_WAIT;
                    wait_nxt    = WCW'(1);
                    if (branch_taken) begin
                        flush_pend_nxt = 1'b1;
                    end
                end else if (load_use) begin
                    IFIDWrite   = 1'b0;
                    PCWrite     = 1'b0;
                    ctrl_bubble = 1'b1;
                    // The branch still resolved; its flush waits for a free cycle.
                    if (branch_taken) begin
                        flush_pend_nxt = 1'b1;
                    end
                end else if (branch_taken || flush_pend_q) begin
                    ifid_flush     = 1'b1;
                    flush_pend_nxt = 1'b0;
                end
            end

            MEM_WAIT: begin
                IFIDWrite   = 1'b0;
                PCWrite     = 1'b0;
                pipe_freeze = 1'b1;
                if (branch_taken) begin
                    flush_pend_nxt = 1'b1;
                end
                // The ready cycle itself stays frozen; release shows next cycle.
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    mem_err_nxt = 1'b1;
                    state_nxt   = RUN;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_q + WCW'(1);
                end
            end

            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    assign mem_err = mem_err_q;

`ifdef HAZ_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!IFIDWrite && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Statistics disabled; CNT_W only sizes the optional counters.
    logic [CNT_W-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int unsigned AW      = 5;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CW      = 4;
    localparam int          CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          idex_memread;
    logic [AW-1:0] idex_rt;
    logic [AW-1:0] ifid_rs;
    logic [AW-1:0] ifid_rt;
    logic          branch_taken;
    logic          dmem_req;
    logic          dmem_ready;
    logic          IFIDWrite;
    logic          PCWrite;
    logic          ctrl_bubble;
    logic          ifid_flush;
    logic          pipe_freeze;
    logic          mem_err;
`ifdef HAZ_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    hazard_stall_ctrl #(
        .REG_AW      (AW),
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .IFIDWrite    (IFIDWrite),
        .PCWrite      (PCWrite),
        .ctrl_bubble  (ctrl_bubble),
        .ifid_flush   (ifid_flush),
        .pipe_freeze  (pipe_freeze),
        .mem_err      (mem_err)
`ifdef HAZ_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: is a memory access outstanding, how many cycles the
    // pipe has been frozen for it so far, deferred flush, sticky error, stats.
    bit m_busy;
    int m_frozen;
    bit m_pend;
    bit m_err;
    int m_stall;
    int m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_frozen = 0;
        m_pend   = 1'b0;
        m_err    = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic drive_idle();
        idex_memread = 1'b0;
        idex_rt      = '0;
        ifid_rs      = '0;
        ifid_rt      = '0;
        branch_taken = 1'b0;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // with the model, then advance the model to the next cycle.
    task automatic apply(input bit mr, input logic [AW-1:0] xrt, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input bit br, input bit req, input bit rdy);
        bit lu, e_hold, e_bub, e_fl, e_frz;
        @(negedge clk);
        idex_memread = mr;
        idex_rt      = xrt;
        ifid_rs      = rs;
        ifid_rt      = rt;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        #1;
        lu     = mr && (xrt != 0) && ((xrt == rs) || (xrt == rt));
        e_hold = 1'b0;
        e_bub  = 1'b0;
        e_fl   = 1'b0;
        e_frz  = 1'b0;
        if (m_busy || (req && !rdy)) begin
            e_hold = 1'b1;
            e_frz  = 1'b1;
        end else if (lu) begin
            e_hold = 1'b1;
            e_bub  = 1'b1;
        end else if (br || m_pend) begin
            e_fl = 1'b1;
        end

        check("IFIDWrite",   32'(IFIDWrite),   32'(!e_hold));
        check("PCWrite",     32'(PCWrite),     32'(!e_hold));
        check("ctrl_bubble", 32'(ctrl_bubble), 32'(e_bub));
        check("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        check("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        check("mem_err",     32'(mem_err),     32'(m_err));
`ifdef HAZ_STATS_EN
        check("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        check("flush_cnt",   32'(flush_cnt),   32'(m_flush));
        if (e_hold && m_stall < CMAX) m_stall++;
        if (e_fl && m_flush < CMAX)   m_flush++;
`endif

        if (e_hold && br) m_pend = 1'b1;
        if (e_fl)         m_pend = 1'b0;
        if (m_busy) begin
            m_frozen++;
            if (rdy) begin
                m_busy = 1'b0;
            end else if (m_frozen == TIMEOUT) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end
        end else if (req && !rdy) begin
            m_busy   = 1'b1;
            m_frozen = 1;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must settle at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        drive_idle();
        rst_n = 1'b0;
        #1;
        check({tag, "_IFIDWrite"},   32'(IFIDWrite),   32'd1);
        check({tag, "_PCWrite"},     32'(PCWrite),     32'd1);
        check({tag, "_ctrl_bubble"}, 32'(ctrl_bubble), 32'd0);
        check({tag, "_ifid_flush"},  32'(ifid_flush),  32'd0);
        check({tag, "_pipe_freeze"}, 32'(pipe_freeze), 32'd0);
        check({tag, "_mem_err"},     32'(mem_err),     32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        do_reset("rst_init");

        // Load-use stall for exactly one cycle, then the zero-register case.
        apply(1, 5'd5, 5'd5, 5'd1, 0, 0, 0);
        check("lu_bubble", 32'(ctrl_bubble), 32'd1);
        check("lu_pcwrite", 32'(PCWrite), 32'd0);
        apply(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("lu_release", 32'(IFIDWrite), 32'd1);
        apply(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("lu_zero_reg", 32'(ctrl_bubble), 32'd0);

        // Memory wait: ready low 3 cycles, high on the 4th; 4 frozen cycles.
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 1, 1);
        check("mw_ready_frozen", 32'(pipe_freeze), 32'd1);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("mw_released", 32'(pipe_freeze), 32'd0);

        // Timeout: ready never comes, mem_err after 8 frozen cycles.
        for (int i = 0; i < int'(TIMEOUT); i++) apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("to_mem_err", 32'(mem_err), 32'd1);
        check("to_back_run", 32'(IFIDWrite), 32'd1);

        // Reset in the middle of a wait aborts it and clears mem_err.
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        do_reset("rst_midwait");

        // Branch during load-use stall: flush exactly once, next cycle.
        apply(1, 5'd7, 5'd3, 5'd7, 1, 0, 0);
        check("df_stall", 32'(ifid_flush), 32'd0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("df_flush", 32'(ifid_flush), 32'd1);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("df_once", 32'(ifid_flush), 32'd0);

        // Branch during a memory freeze is also deferred to the first free cycle.
        apply(0, 0, 0, 0, 1, 1, 0);
        apply(0, 0, 0, 0, 1, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("df_mem_flush", 32'(ifid_flush), 32'd1);

`ifdef HAZ_STATS_EN
        do_reset("rst_stats");
        apply(1, 5'd2, 5'd2, 5'd0, 0, 0, 0);
        apply(1, 5'd3, 5'd0, 5'd3, 0, 0, 0);
        apply(1, 5'd4, 5'd4, 5'd4, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("st_stall3", 32'(stall_cnt), 32'd3);
        check("st_flush1", 32'(flush_cnt), 32'd1);
`endif

        // Randomized traffic; small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            rdy = ($urandom_range(0, 3) == 0);
            apply(($urandom_range(0, 2) == 0),
                  AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  rdy);
        end

`ifdef HAZ_STATS_EN
        check("st_stall_sat", 32'(stall_cnt), 32'(CMAX));
        check("st_flush_sat", 32'(flush_cnt), 32'(CMAX));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
